alu_rs_bank: RTL and testbench
==============================

ALU_RS_BANK -- requirements
Module: alu_rs_bank

Interface
REQ-001 Parameter DATA_W, default 16, operand/result data width.
REQ-002 Parameter TAG_W, default 3, ROB/producer tag width.
REQ-003 Parameter N_RS, default 4, number of reservation-station entries (2..8).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous squash of all entries and output register.
REQ-007 iss_valid  in  1  dispatch request; iss_ready  out  1  at least one free entry.
REQ-008 iss_op  in  4  ALU opcode; iss_dest  in  TAG_W  destination tag.
REQ-009 iss_vj, iss_vk  in  DATA_W  operand values; iss_rj, iss_rk  in  1  operand ready; iss_qj, iss_qk  in  TAG_W  producer tags when not ready.
REQ-010 cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  DATA_W  common data bus snoop.
REQ-011 ex_valid  out  1; ex_ready  in  1  handshake to CDB arbiter/ALU stage.
REQ-012 ex_op  out  4; ex_a, ex_b  out  DATA_W; ex_dest  out  TAG_W  dispatched instruction.
REQ-013 busy  out  N_RS  per-entry occupancy.

Function
REQ-014 Dispatch accepted when iss_valid && iss_ready; entry written is the lowest-index free entry.
REQ-015 iss_ready SHALL be combinational: high iff some busy bit is 0; full bank drops it.
REQ-016 Each entry SHALL store op, dest, Vj, Vk, rj, rk, Qj, Qk, and an age stamp.
REQ-017 Every cycle, for each busy entry with rj=0 and cdb_valid && cdb_tag==Qj, Vj<=cdb_data and rj<=1; same independently for k.
REQ-018 Dispatch-cycle bypass: operand not ready at iss but matching the CDB in the same cycle SHALL be captured as ready.
REQ-019 Entry is eligible when busy && rj && rk; a CDB wake-up makes it eligible the following cycle.
REQ-020 Output register: loaded when eligible entry exists and (ex_valid==0 || ex_ready==1); selected entry freed in the same edge.
REQ-021 Selected entry SHALL be the eligible entry with the oldest age stamp (see REQ-030).
REQ-022 Latency: operands ready at dispatch, output register empty -> ex_valid high the cycle after dispatch.
REQ-023 ex_* SHALL hold stable while ex_valid && !ex_ready; ex_valid drops after ex_ready handshake if nothing eligible.
REQ-024 Entry freed by selection SHALL be reusable by dispatch the next cycle, never the same cycle.
REQ-025 Age stamps: wrapping counter of width clog2(N_RS)+1 incremented per dispatch; comparison by modular difference, correct across wrap.
REQ-026 flush SHALL clear busy, ex_valid and age counter at the next edge, overriding dispatch, wake-up and selection that cycle.

Reset
REQ-027 rst_n low SHALL immediately clear busy to 0, ex_valid to 0, age counter to 0, ex_op/ex_a/ex_b/ex_dest to 0.
REQ-028 iss_ready SHALL be 1 during and after reset; reset asserted mid-operation discards all entries without emitting ex_valid.
REQ-029 Entry payload fields not cleared by reset are don't-care while busy=0.

Configuration
REQ-030 Macro ALU_RS_AGE_EN: defined -> oldest-first selection per REQ-021/025; undefined -> lowest-index eligible entry selected, age counter and stamps removed.

Verification
REQ-031 Reset, dispatch op=ADD vj=5 vk=7 rj=rk=1 dest=2, ex_ready=1 -> next cycle ex_valid=1 ex_a=5 ex_b=7 ex_dest=2, busy=0 after.
REQ-032 Dispatch with rj=0 qj=3; two cycles later cdb_valid tag=3 data=0x1234 -> ex_a=0x1234 appears one cycle after the CDB cycle.
REQ-033 Fill N_RS=4 entries with unready operands -> iss_ready=0; further iss_valid ignored; one wake-up+dispatch re-raises iss_ready next cycle.
REQ-034 Two entries ready same cycle, older in index 3 (ALU_RS_AGE_EN) -> index 3 dispatched first; without macro index 0 first.
REQ-035 Hold ex_ready=0 for 5 cycles with ex_valid=1 -> ex_* unchanged; flush on cycle 3 -> ex_valid=0 and busy=0 next cycle.
REQ-036 Dispatch with qk=4 in same cycle as cdb tag=4 data=9 -> entry captured ready, ex_b=9 next cycle.

Source files
------------

// File: rtl/alu_rs_bank_if.sv
// Dispatch, CDB snoop and execute handshake bundle for the ALU reservation-station bank.
// The slave modport is the bank; the master side is the dispatcher, CDB and ALU stage.
interface alu_rs_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
);
  logic              iss_valid;
  logic              iss_ready;
  logic [3:0]        iss_op;
  logic [TAG_W-1:0]  iss_dest;
  logic [DATA_W-1:0] iss_vj;
  logic [DATA_W-1:0] iss_vk;
  logic              iss_rj;
  logic              iss_rk;
  logic [TAG_W-1:0]  iss_qj;
  logic [TAG_W-1:0]  iss_qk;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [TAG_W-1:0]  ex_dest;

  modport master (
    output iss_valid, iss_op, iss_dest, iss_vj, iss_vk, iss_rj, iss_rk, iss_qj, iss_qk,
    output cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  iss_ready, ex_valid, ex_op, ex_a, ex_b, ex_dest
  );

  modport slave (
    input  iss_valid, iss_op, iss_dest, iss_vj, iss_vk, iss_rj, iss_rk, iss_qj, iss_qk,
    input  cdb_valid, cdb_tag, cdb_data, ex_ready,
    output iss_ready, ex_valid, ex_op, ex_a, ex_b, ex_dest
  );
endinterface

// File: rtl/alu_rs_bank.sv
// ALU reservation-station bank: CDB wake-up, dispatch bypass, one-deep output register.
// Macro ALU_RS_AGE_EN: oldest-first selection via age stamps; otherwise lowest index wins.
module alu_rs_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned N_RS   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  alu_rs_bank_if.slave    bus,
  output logic [N_RS-1:0] busy
);
  localparam int unsigned IdxW = $clog2(N_RS);

  logic [N_RS-1:0]   busy_q, busy_d, rj_q, rk_q, elig;
  logic [3:0]        op_q   [N_RS];
  logic [TAG_W-1:0]  dest_q [N_RS];
  logic [TAG_W-1:0]  qj_q   [N_RS];
  logic [TAG_W-1:0]  qk_q   [N_RS];
  logic [DATA_W-1:0] vj_q   [N_RS];
  logic [DATA_W-1:0] vk_q   [N_RS];

  logic              ex_valid_q, ex_valid_d;
  logic [3:0]        ex_op_q;
  logic [DATA_W-1:0] ex_a_q, ex_b_q;
  logic [TAG_W-1:0]  ex_dest_q;

  logic              free_found, sel_found, iss_fire, load;
  logic [IdxW-1:0]   free_idx, sel_idx;
  logic              iss_rj_byp, iss_rk_byp;
  logic [DATA_W-1:0] iss_vj_byp, iss_vk_byp;

`ifdef ALU_RS_AGE_EN
  localparam int unsigned AgeW = $clog2(N_RS) + 1;
  logic [AgeW-1:0] age_cnt_q;
  logic [AgeW-1:0] age_q [N_RS];

  // Live stamps never span more than N_RS dispatches, so the sign of the wrapped difference
  // orders them correctly across counter wrap.
  function automatic logic is_older(input logic [AgeW-1:0] a, input logic [AgeW-1:0] b);
    logic [AgeW-1:0] diff;
    diff = a - b;
    return diff[AgeW-1];
  endfunction
`endif

  assign bus.iss_ready = ~&busy_q;
  assign iss_fire      = bus.iss_valid && bus.iss_ready;
  assign elig          = busy_q & rj_q & rk_q;
  assign load          = sel_found && (!ex_valid_q || bus.ex_ready);

  // Operands waiting on the tag broadcast this very cycle enter the bank already ready.
  assign iss_rj_byp = bus.iss_rj || (bus.cdb_valid && bus.cdb_tag == bus.iss_qj);
  assign iss_rk_byp = bus.iss_rk || (bus.cdb_valid && bus.cdb_tag == bus.iss_qk);
  assign iss_vj_byp = bus.iss_rj ? bus.iss_vj : bus.cdb_data;
  assign iss_vk_byp = bus.iss_rk ? bus.iss_vk : bus.cdb_data;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N_RS; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_RS; i++) begin
      if (elig[i]) begin
`ifdef ALU_RS_AGE_EN
        if (!sel_found || is_older(age_q[i], age_q[sel_idx])) begin
`else
        if (!sel_found) begin
`endif
          sel_found = 1'b1;
          sel_idx   = IdxW'(i);
        end
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    ex_valid_d = ex_valid_q;
    if (load) begin
      busy_d[sel_idx] = 1'b0;
      ex_valid_d      = 1'b1;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (iss_fire) busy_d[free_idx] = 1'b1;
    if (flush) begin
      busy_d     = '0;
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_dest_q  <= '0;
`ifdef ALU_RS_AGE_EN
      age_cnt_q  <= '0;
`endif
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      if (load && !flush) begin
        ex_op_q   <= op_q[sel_idx];
        ex_a_q    <= vj_q[sel_idx];
        ex_b_q    <= vk_q[sel_idx];
        ex_dest_q <= dest_q[sel_idx];
      end
`ifdef ALU_RS_AGE_EN
      if (flush)         age_cnt_q <= '0;
      else if (iss_fire) age_cnt_q <= age_cnt_q + 1'b1;
`endif
    end
  end

  // Entry payload is don't-care while the entry is free, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_RS; i++) begin
      if (iss_fire && free_idx == IdxW'(i)) begin
        op_q[i]   <= bus.iss_op;
        dest_q[i] <= bus.iss_dest;
        qj_q[i]   <= bus.iss_qj;
        qk_q[i]   <= bus.iss_qk;
        vj_q[i]   <= iss_vj_byp;
        vk_q[i]   <= iss_vk_byp;
        rj_q[i]   <= iss_rj_byp;
        rk_q[i]   <= iss_rk_byp;
`ifdef ALU_RS_AGE_EN
        age_q[i]  <= age_cnt_q;
`endif
      end else begin
        if (busy_q[i] && !rj_q[i] && bus.cdb_valid && bus.cdb_tag == qj_q[i]) begin
          vj_q[i] <= bus.cdb_data;
          rj_q[i] <= 1'b1;
        end
        if (busy_q[i] && !rk_q[i] && bus.cdb_valid && bus.cdb_tag == qk_q[i]) begin
          vk_q[i] <= bus.cdb_data;
          rk_q[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_dest  = ex_dest_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_rs_bank.sv
// Self-checking bench for alu_rs_bank: vector table, directed corner sequences and a
// randomized run against a sequence-number reference model.
module tb_alu_rs_bank;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int N  = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [N-1:0] busy;

  alu_rs_bank_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  alu_rs_bank #(.DATA_W(DW), .TAG_W(TW), .N_RS(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_op = '0; bus.iss_dest = '0;
    bus.iss_vj = '0; bus.iss_vk = '0; bus.iss_rj = 1'b0; bus.iss_rk = 1'b0;
    bus.iss_qj = '0; bus.iss_qk = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.ex_ready = 1'b1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                          input logic rj, input logic rk, input logic [TW-1:0] qj,
                          input logic [TW-1:0] qk, input logic [TW-1:0] dest);
    bus.iss_valid = 1'b1; bus.iss_op = op; bus.iss_vj = vj; bus.iss_vk = vk;
    bus.iss_rj = rj; bus.iss_rk = rk; bus.iss_qj = qj; bus.iss_qk = qk; bus.iss_dest = dest;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic hard_reset();
    idle();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model: entries carry an unbounded dispatch sequence number; oldest = smallest.
  logic          m_busy [N];
  logic          m_rj [N], m_rk [N];
  logic [3:0]    m_op [N];
  logic [TW-1:0] m_dest [N], m_qj [N], m_qk [N];
  logic [DW-1:0] m_vj [N], m_vk [N];
  int            m_seq [N];
  int            m_seq_cnt;
  logic          m_exv;
  logic [3:0]    m_ex_op;
  logic [DW-1:0] m_ex_a, m_ex_b;
  logic [TW-1:0] m_ex_dest;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0; m_rj[i] = 1'b0; m_rk[i] = 1'b0; m_seq[i] = 0;
    end
    m_seq_cnt = 0; m_exv = 1'b0;
    m_ex_op = '0; m_ex_a = '0; m_ex_b = '0; m_ex_dest = '0;
  endtask

  task automatic model_step();
    int sel;
    int fr;
    sel = -1;
    fr  = -1;
    if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_exv = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && m_rj[i] && m_rk[i]) begin
`ifdef ALU_RS_AGE_EN
          if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
        if (!m_busy[i] && fr < 0) fr = i;
      end
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && bus.cdb_valid) begin
          if (!m_rj[i] && bus.cdb_tag == m_qj[i]) begin m_vj[i] = bus.cdb_data; m_rj[i] = 1'b1; end
          if (!m_rk[i] && bus.cdb_tag == m_qk[i]) begin m_vk[i] = bus.cdb_data; m_rk[i] = 1'b1; end
        end
      end
      if (sel >= 0 && (!m_exv || bus.ex_ready)) begin
        m_exv = 1'b1; m_ex_op = m_op[sel]; m_ex_a = m_vj[sel]; m_ex_b = m_vk[sel];
        m_ex_dest = m_dest[sel]; m_busy[sel] = 1'b0;
      end else if (bus.ex_ready) begin
        m_exv = 1'b0;
      end
      if (bus.iss_valid && fr >= 0) begin
        m_busy[fr] = 1'b1; m_op[fr] = bus.iss_op; m_dest[fr] = bus.iss_dest;
        m_qj[fr] = bus.iss_qj; m_qk[fr] = bus.iss_qk;
        m_rj[fr] = bus.iss_rj || (bus.cdb_valid && bus.cdb_tag == bus.iss_qj);
        m_rk[fr] = bus.iss_rk || (bus.cdb_valid && bus.cdb_tag == bus.iss_qk);
        m_vj[fr] = bus.iss_rj ? bus.iss_vj : bus.cdb_data;
        m_vk[fr] = bus.iss_rk ? bus.iss_vk : bus.cdb_data;
        m_seq[fr] = m_seq_cnt;
        m_seq_cnt++;
      end
    end
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] vj, vk;
    logic          rj, rk;
    logic [TW-1:0] qj, qk, dest;
    logic          cdb_v;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          exp_v;
    logic [DW-1:0] exp_a, exp_b;
    logic [N-1:0]  exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [N-1:0]  exp_busy;
    logic [TW-1:0] first_dest, second_dest;

    vecs[0] = '{op:4'd0, vj:16'd5, vk:16'd7, rj:1, rk:1, qj:0, qk:0, dest:3'd2,
                cdb_v:0, cdb_tag:0, cdb_data:16'h0, exp_v:1, exp_a:16'd5, exp_b:16'd7, exp_busy:4'b0000};
    vecs[1] = '{op:4'd1, vj:16'h11, vk:16'h0, rj:1, rk:0, qj:0, qk:3'd4, dest:3'd3,
                cdb_v:1, cdb_tag:3'd4, cdb_data:16'd9, exp_v:1, exp_a:16'h11, exp_b:16'd9, exp_busy:4'b0000};
    vecs[2] = '{op:4'd2, vj:16'hdead, vk:16'h22, rj:0, rk:1, qj:3'd1, qk:0, dest:3'd4,
                cdb_v:1, cdb_tag:3'd1, cdb_data:16'hbeef, exp_v:1, exp_a:16'hbeef, exp_b:16'h22, exp_busy:4'b0000};
    vecs[3] = '{op:4'd3, vj:16'd1, vk:16'd2, rj:0, rk:1, qj:3'd2, qk:0, dest:3'd5,
                cdb_v:1, cdb_tag:3'd5, cdb_data:16'h77, exp_v:0, exp_a:16'h0, exp_b:16'h0, exp_busy:4'b0001};
    vecs[4] = '{op:4'd4, vj:16'd0, vk:16'd0, rj:0, rk:0, qj:3'd6, qk:3'd6, dest:3'd6,
                cdb_v:1, cdb_tag:3'd6, cdb_data:16'h0aaa, exp_v:1, exp_a:16'h0aaa, exp_b:16'h0aaa, exp_busy:4'b0000};
    vecs[5] = '{op:4'd5, vj:16'd3, vk:16'd4, rj:0, rk:1, qj:3'd3, qk:0, dest:3'd7,
                cdb_v:0, cdb_tag:3'd3, cdb_data:16'h99, exp_v:0, exp_a:16'h0, exp_b:16'h0, exp_busy:4'b0001};
    vecs[6] = '{op:4'd15, vj:16'hffff, vk:16'h8000, rj:1, rk:1, qj:0, qk:0, dest:3'd0,
                cdb_v:0, cdb_tag:0, cdb_data:16'h0, exp_v:1, exp_a:16'hffff, exp_b:16'h8000, exp_busy:4'b0000};

    // Reset state, while rst_n is still low.
    idle();
    #1;
    check("rst_busy", busy, 0);
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_iss_ready", bus.iss_ready, 1);
    check("rst_ex_a", bus.ex_a, 0);
    check("rst_ex_op", bus.ex_op, 0);
    check("rst_ex_dest", bus.ex_dest, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-instruction vectors from an empty bank.
    for (int k = 0; k < 7; k++) begin
      do_flush();
      dispatch(vecs[k].op, vecs[k].vj, vecs[k].vk, vecs[k].rj, vecs[k].rk,
               vecs[k].qj, vecs[k].qk, vecs[k].dest);
      if (vecs[k].cdb_v) cdb(vecs[k].cdb_tag, vecs[k].cdb_data);
      tick();
      idle();
      tick();
      check($sformatf("vec%0d_ex_valid", k), bus.ex_valid, vecs[k].exp_v);
      check($sformatf("vec%0d_busy", k), busy, vecs[k].exp_busy);
      if (vecs[k].exp_v) begin
        check($sformatf("vec%0d_ex_a", k), bus.ex_a, vecs[k].exp_a);
        check($sformatf("vec%0d_ex_b", k), bus.ex_b, vecs[k].exp_b);
        check($sformatf("vec%0d_ex_dest", k), bus.ex_dest, vecs[k].dest);
        check($sformatf("vec%0d_ex_op", k), bus.ex_op, vecs[k].op);
      end
    end

    // Late wake-up: CDB two cycles after dispatch.
    hard_reset();
    dispatch(4'd1, 16'h0, 16'd4, 1'b0, 1'b1, 3'd3, 3'd0, 3'd5);
    tick();
    idle();
    tick();
    cdb(3'd3, 16'h1234);
    tick();
    idle();
    check("wake_not_yet", bus.ex_valid, 0);
    tick();
    check("wake_ex_valid", bus.ex_valid, 1);
    check("wake_ex_a", bus.ex_a, 16'h1234);
    check("wake_ex_b", bus.ex_b, 16'd4);

    // Full bank: further dispatch ignored, one wake-up frees a slot.
    do_flush();
    for (int i = 0; i < N; i++) begin
      dispatch(4'(i), 16'h0, 16'(i), 1'b0, 1'b1, 3'(i + 1), 3'd0, 3'(i));
      tick();
    end
    idle();
    check("full_iss_ready", bus.iss_ready, 0);
    check("full_busy", busy, 4'b1111);
    dispatch(4'd7, 16'd1, 16'd1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd6);
    tick();
    idle();
    check("full_ignored_busy", busy, 4'b1111);
    check("full_ignored_ex_valid", bus.ex_valid, 0);
    cdb(3'd1, 16'h55);
    tick();
    idle();
    check("full_still_full", bus.iss_ready, 0);
    tick();
    check("full_reraised", bus.iss_ready, 1);
    check("full_busy_after", busy, 4'b1110);
    check("full_ex_a", bus.ex_a, 16'h55);

    // Age ordering: index 3 holds an older instruction than a re-dispatched index 0.
    do_flush();
    for (int i = 0; i < N; i++) begin
      dispatch(4'(i), 16'h0, 16'(i), 1'b0, 1'b1, (i == 0) ? 3'd1 : ((i == 3) ? 3'd5 : 3'd2),
               3'd0, (i == 0) ? 3'd7 : 3'(i));
      tick();
    end
    idle();
    cdb(3'd1, 16'h10);
    tick();
    idle();
    tick();
    check("age_first_out", bus.ex_dest, 3'd7);
    dispatch(4'd9, 16'h0, 16'h9, 1'b0, 1'b1, 3'd5, 3'd0, 3'd0);
    tick();
    idle();
    check("age_refill_busy", busy, 4'b1111);
    cdb(3'd5, 16'h50);
    tick();
    idle();
`ifdef ALU_RS_AGE_EN
    first_dest = 3'd3; second_dest = 3'd0;
`else
    first_dest = 3'd0; second_dest = 3'd3;
`endif
    tick();
    check("age_sel1_valid", bus.ex_valid, 1);
    check("age_sel1_dest", bus.ex_dest, first_dest);
    check("age_sel1_a", bus.ex_a, 16'h50);
    tick();
    check("age_sel2_dest", bus.ex_dest, second_dest);

    // Stall holds the output register; flush squashes it and the bank.
    do_flush();
    dispatch(4'd2, 16'h100, 16'h200, 1'b1, 1'b1, 3'd0, 3'd0, 3'd1);
    bus.ex_ready = 1'b0;
    tick();
    dispatch(4'd3, 16'h300, 16'h400, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2);
    tick();
    idle();
    bus.ex_ready = 1'b0;
    check("stall_ex_valid", bus.ex_valid, 1);
    check("stall_busy", busy, 4'b0010);
    for (int s = 0; s < 2; s++) begin
      tick();
      check($sformatf("stall%0d_ex_valid", s), bus.ex_valid, 1);
      check($sformatf("stall%0d_ex_a", s), bus.ex_a, 16'h100);
      check($sformatf("stall%0d_ex_b", s), bus.ex_b, 16'h200);
      check($sformatf("stall%0d_ex_dest", s), bus.ex_dest, 3'd1);
      check($sformatf("stall%0d_ex_op", s), bus.ex_op, 4'd2);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ex_valid", bus.ex_valid, 0);
    check("flush_busy", busy, 0);
    bus.ex_ready = 1'b1;
    tick();
    check("flush_stays_empty", bus.ex_valid, 0);

    // Asynchronous reset in the middle of operation.
    dispatch(4'd6, 16'h66, 16'h77, 1'b1, 1'b1, 3'd0, 3'd0, 3'd4);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ex_valid", bus.ex_valid, 0);
    check("midrst_iss_ready", bus.iss_ready, 1);
    check("midrst_ex_a", bus.ex_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_no_emit", bus.ex_valid, 0);

    // Randomized run against the reference model.
    hard_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int min_seq;
      bit any_live;
      any_live = 1'b0;
      min_seq  = 0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && (!any_live || m_seq[i] < min_seq)) begin
          any_live = 1'b1;
          min_seq  = m_seq[i];
        end
      end
      bus.iss_valid = ($urandom_range(0, 1) == 1);
      // Keep live stamps within half the stamp range so wrapped comparison stays meaningful.
      if (any_live && (m_seq_cnt - min_seq) >= N) bus.iss_valid = 1'b0;
      bus.iss_op = 4'($urandom); bus.iss_dest = 3'($urandom);
      bus.iss_vj = 16'($urandom); bus.iss_vk = 16'($urandom);
      bus.iss_rj = ($urandom_range(0, 2) == 0); bus.iss_rk = ($urandom_range(0, 2) == 0);
      bus.iss_qj = 3'($urandom); bus.iss_qk = 3'($urandom);
      bus.cdb_valid = ($urandom_range(0, 1) == 1);
      bus.cdb_tag = 3'($urandom); bus.cdb_data = 16'($urandom);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      model_step();
      tick();
      exp_busy = '0;
      for (int i = 0; i < N; i++) exp_busy[i] = m_busy[i];
      check("rnd_ex_valid", bus.ex_valid, m_exv);
      check("rnd_busy", busy, exp_busy);
      check("rnd_iss_ready", bus.iss_ready, ~&exp_busy);
      if (m_exv) begin
        check("rnd_ex_op", bus.ex_op, m_ex_op);
        check("rnd_ex_a", bus.ex_a, m_ex_a);
        check("rnd_ex_b", bus.ex_b, m_ex_b);
        check("rnd_ex_dest", bus.ex_dest, m_ex_dest);
      end
    end
    flush = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
